// File: rtl/bist_response_analyzer_if.sv
// Handshake and result bus between the BIST controller/UUT side and the response analyzer.
interface bist_response_analyzer_if #(
  parameter int RES_W = 5,
  parameter int CNT_W = 8
);
  logic             start;
  logic             abort;
  logic [RES_W-1:0] result;
  logic             res_valid;
  logic             tpg_clear;
  logic             busy;
  logic             done;
  logic             pass;
  logic [RES_W-1:0] signature;
  logic [CNT_W-1:0] count;

  modport master (
    output start, abort, result, res_valid,
    input  tpg_clear, busy, done, pass, signature, count
  );

  modport slave (
    input  start, abort, result, res_valid,
    output tpg_clear, busy, done, pass, signature, count
  );
endinterface

// File: rtl/bist_response_analyzer.sv
// MISR-based response compactor: folds UUT results into a signature over a fixed
// pattern count, then compares against a golden value and reports pass/fail.
module bist_response_analyzer #(
  parameter int               RES_W     = 5,
  parameter int               CNT_W     = 8,
  parameter int               PATTERNS  = 15,
  parameter logic [RES_W-1:0] MISR_POLY = 5'b00101,
  parameter logic [RES_W-1:0] SEED      = 5'b00000,
  parameter logic [RES_W-1:0] GOLDEN    = 5'b00000
) (
  input logic                     clk,
  input logic                     reset,
  bist_response_analyzer_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state;
  logic [RES_W-1:0] sig;
  logic [RES_W-1:0] sig_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic             tpg_clear;
  logic             pass;

  // Bit 0 always takes the feedback; higher bits only where MISR_POLY has a tap.
  always_comb begin
    sig_next[0] = sig[RES_W-1] ^ bus.result[0];
    for (int i = 1; i < RES_W; i++)
      sig_next[i] = sig[i-1] ^ bus.result[i] ^ (MISR_POLY[i] & sig[RES_W-1]);
  end

  assign count_inc = count + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sig       <= SEED;
      count     <= '0;
      tpg_clear <= 1'b0;
      pass      <= 1'b0;
    end else begin
      tpg_clear <= 1'b0;
      if (bus.abort) begin
        // signature and count are left as-is for post-mortem inspection
        state <= IDLE;
        pass  <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (bus.start) begin
              state     <= RUN;
              sig       <= SEED;
              count     <= '0;
              pass      <= 1'b0;
              tpg_clear <= 1'b1;
            end
          end
          RUN: begin
            if (bus.res_valid) begin
              sig   <= sig_next;
              count <= count_inc;
              if (count_inc == CNT_W'(PATTERNS)) state <= CHECK;
            end
          end
          CHECK: begin
            pass  <= (sig == GOLDEN);
            state <= DONE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.tpg_clear = tpg_clear;
  assign bus.busy      = (state == RUN) || (state == CHECK);
  assign bus.done      = (state == DONE);
  assign bus.pass      = pass;
  assign bus.signature = sig;
  assign bus.count     = count;
endmodule

// File: tb/tb_bist_response_analyzer.sv
// Directed/randomized bench for bist_response_analyzer; three instances cover the
// default session plus single-pattern golden/seed cases.
module tb_bist_response_analyzer;
  logic clk = 1'b0;
  logic reset;
  logic start, abort, res_valid;
  logic [4:0] r0, r1, r2;
  int checks = 0;
  int errors = 0;

  logic [4:0] dq[$];
  bit         vq[$];

  always #5 clk = ~clk;

  bist_response_analyzer_if #(.RES_W(5), .CNT_W(8)) b0 ();
  bist_response_analyzer_if #(.RES_W(5), .CNT_W(8)) b1 ();
  bist_response_analyzer_if #(.RES_W(5), .CNT_W(8)) b2 ();

  assign b0.start = start;  assign b0.abort = abort;  assign b0.res_valid = res_valid;  assign b0.result = r0;
  assign b1.start = start;  assign b1.abort = abort;  assign b1.res_valid = res_valid;  assign b1.result = r1;
  assign b2.start = start;  assign b2.abort = abort;  assign b2.res_valid = res_valid;  assign b2.result = r2;

  bist_response_analyzer dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
  bist_response_analyzer #(.PATTERNS(1), .SEED(5'h00), .GOLDEN(5'h13))
    dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
  bist_response_analyzer #(.PATTERNS(1), .SEED(5'h10), .GOLDEN(5'h00))
    dut2 (.clk(clk), .reset(reset), .bus(b2.slave));

  // Signature as a GF(2) polynomial: shift by x, reduce by x^5 + x^2 + 1, add the result word.
  function automatic logic [4:0] misr(input logic [4:0] s, input logic [4:0] r);
    logic [5:0] t;
    t = {s, 1'b0};
    if (t[5]) t = t ^ 6'b100101;
    return t[4:0] ^ r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue start from IDLE/DONE and check the first RUN cycle on dut0.
  task automatic begin_session(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_tpg_clear"}, 32'(b0.tpg_clear), 32'd1);
    chk({tag, "_busy"},      32'(b0.busy),      32'd1);
    chk({tag, "_done"},      32'(b0.done),      32'd0);
    chk({tag, "_count"},     32'(b0.count),     32'd0);
    chk({tag, "_sig_seed"},  32'(b0.signature), 32'd0);
  endtask

  // Feed dq under the valid pattern vq into dut0, follow through CHECK to DONE.
  task automatic run_d0(input string tag, output int busy_cycles);
    int acc;
    logic [4:0] ms;
    acc = 0;
    ms = 5'h00;
    busy_cycles = 0;
    foreach (vq[j]) begin
      res_valid = vq[j];
      r0 = vq[j] ? dq[acc] : 5'($urandom);
      step();
      if (vq[j]) begin
        ms = misr(ms, dq[acc]);
        acc++;
      end
      if (b0.busy) busy_cycles++;
      if (j == 0) chk({tag, "_tpg_once"}, 32'(b0.tpg_clear), 32'd0);
      chk({tag, "_count"}, 32'(b0.count), 32'(acc));
      chk({tag, "_sig"},   32'(b0.signature), 32'(ms));
    end
    res_valid = 1'b0;
    chk({tag, "_check_busy"}, 32'(b0.busy), 32'd1);
    chk({tag, "_check_done"}, 32'(b0.done), 32'd0);
    step();
    if (b0.busy) busy_cycles++;
    chk({tag, "_done"},      32'(b0.done),      32'd1);
    chk({tag, "_pass"},      32'(b0.pass),      32'(ms == 5'h00));
    chk({tag, "_final_sig"}, 32'(b0.signature), 32'(ms));
    chk({tag, "_final_cnt"}, 32'(b0.count),     32'd15);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    logic [4:0] ms;
    reset = 1'b1; start = 1'b0; abort = 1'b0; res_valid = 1'b0;
    r0 = '0; r1 = '0; r2 = '0;
    repeat (3) step();
    reset = 1'b0;

    // Reset state and idle behaviour with noise on the result bus.
    for (int i = 0; i < 3; i++) begin
      res_valid = 1'($urandom); r0 = 5'($urandom);
      step();
      chk("idle_sig",  32'(b0.signature), 32'd0);
      chk("idle_cnt",  32'(b0.count),     32'd0);
      chk("idle_busy", 32'(b0.busy),      32'd0);
      chk("idle_done", 32'(b0.done),      32'd0);
      chk("idle_pass", 32'(b0.pass),      32'd0);
      chk("idle_tpg",  32'(b0.tpg_clear), 32'd0);
    end
    chk("seed_reset_d2", 32'(b2.signature), 32'h10);

    // Single-pattern sessions: golden match and seed feedback.
    res_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("p1_tpg",      32'(b1.tpg_clear), 32'd1);
    chk("p1_seed_d2",  32'(b2.signature), 32'h10);
    res_valid = 1'b1; r0 = 5'h13; r1 = 5'h13; r2 = 5'h00;
    step();
    res_valid = 1'b0;
    chk("p1_sig",      32'(b1.signature), 32'h13);
    chk("p1_cnt",      32'(b1.count),     32'd1);
    chk("p1_tpg_off",  32'(b1.tpg_clear), 32'd0);
    chk("p1_chk_busy", 32'(b1.busy),      32'd1);
    chk("p1_chk_done", 32'(b1.done),      32'd0);
    chk("p3_sig",      32'(b2.signature), 32'h05);
    step();
    chk("p1_done",     32'(b1.done),      32'd1);
    chk("p1_pass",     32'(b1.pass),      32'd1);
    chk("p3_done",     32'(b2.done),      32'd1);
    chk("p3_pass",     32'(b2.pass),      32'd0);
    res_valid = 1'b1; r1 = 5'($urandom);
    step();
    chk("p1_hold_sig", 32'(b1.signature), 32'h13);
    chk("p1_hold_cnt", 32'(b1.count),     32'd1);
    chk("p1_hold_done",32'(b1.done),      32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0; res_valid = 1'b0;
    chk("p1_abort_done", 32'(b1.done),      32'd0);
    chk("p1_abort_pass", 32'(b1.pass),      32'd0);
    chk("p1_abort_sig",  32'(b1.signature), 32'h13);
    chk("d0_abort_busy", 32'(b0.busy),      32'd0);

    // Fifteen zero results with exactly three interleaved gaps.
    begin_session("zero");
    dq.delete(); vq.delete();
    for (int i = 0; i < 15; i++) dq.push_back(5'h00);
    for (int i = 0; i < 18; i++) vq.push_back(1'b1);
    begin
      int z;
      z = 0;
      while (z < 3) begin
        int k;
        k = $urandom_range(0, 16);
        if (vq[k]) begin vq[k] = 1'b0; z++; end
      end
    end
    run_d0("zero", bc);
    chk("zero_busy_cycles", 32'(bc + 1), 32'd19);

    // Restart straight from DONE, repeat the zero session.
    begin_session("restart");
    run_d0("restart", bc);

    // Random data session, then an exact replay from DONE.
    dq.delete(); vq.delete();
    for (int i = 0; i < 15; i++) dq.push_back(5'($urandom));
    begin
      int nv;
      nv = 0;
      while (nv < 15) begin
        bit v;
        v = ($urandom_range(0, 3) != 0);
        vq.push_back(v);
        if (v) nv++;
      end
    end
    begin_session("rand");
    run_d0("rand", bc);
    begin_session("replay");
    run_d0("replay", bc);

    // Abort coincident with a valid result at count 7.
    begin_session("abort");
    ms = 5'h00;
    for (int i = 0; i < 7; i++) begin
      r0 = 5'($urandom); res_valid = 1'b1;
      ms = misr(ms, r0);
      step();
    end
    chk("abort_pre_cnt", 32'(b0.count), 32'd7);
    abort = 1'b1; res_valid = 1'b1; r0 = 5'($urandom);
    step();
    abort = 1'b0;
    chk("abort_cnt",  32'(b0.count),     32'd7);
    chk("abort_sig",  32'(b0.signature), 32'(ms));
    chk("abort_busy", 32'(b0.busy),      32'd0);
    chk("abort_done", 32'(b0.done),      32'd0);
    chk("abort_pass", 32'(b0.pass),      32'd0);
    r0 = 5'($urandom);
    step();
    res_valid = 1'b0;
    chk("abort_idle_cnt", 32'(b0.count), 32'd7);
    begin_session("post_abort");

    // Asynchronous reset in the middle of a session.
    for (int i = 0; i < 3; i++) begin
      r0 = 5'($urandom) | 5'h01; res_valid = 1'b1;
      step();
    end
    res_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("areset_sig",  32'(b0.signature), 32'd0);
    chk("areset_cnt",  32'(b0.count),     32'd0);
    chk("areset_busy", 32'(b0.busy),      32'd0);
    chk("areset_done", 32'(b0.done),      32'd0);
    chk("areset_pass", 32'(b0.pass),      32'd0);
    chk("areset_tpg",  32'(b0.tpg_clear), 32'd0);
    chk("areset_seed_d2", 32'(b2.signature), 32'h10);
    step();
    reset = 1'b0;
    step();
    chk("post_reset_done", 32'(b0.done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bist_response_analyzer.md
Name: bist_response_analyzer

Overview:
Downstream stage of the LFSR test-pattern generator in the ALU built-in self-test path. It consumes the unit-under-test result for each applied pattern and compacts the results into a multiple-input signature register (MISR). After a fixed number of patterns it compares the signature against a golden value and reports pass/fail. A start/done handshake lets the BIST controller run sessions back to back.

Parameters:
RES_W, 5, width of the result word consumed per pattern (4-bit result plus carry).
CNT_W, 8, width of the pattern counter.
PATTERNS, 15, patterns compacted per session; legal range 1..2^CNT_W-1.
MISR_POLY, 5'b00101, feedback taps; bit i set means sig[RES_W-1] is XORed into bit i, for i ≥ 1.
SEED, 5'b00000, signature value loaded at session start.
GOLDEN, 5'b00000, expected final signature.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  session request; sampled in IDLE and DONE only
abort  in  1  cancel a session; returns to IDLE
result  in  RES_W  unit-under-test output for the current pattern
res_valid  in  1  result qualifies this cycle
tpg_clear  out  1  one-cycle pulse that resynchronises the pattern generator at session start
busy  out  1  high in RUN and CHECK
done  out  1  high in DONE
pass  out  1  signature matched GOLDEN; meaningful only while done=1
signature  out  RES_W  current MISR contents
count  out  CNT_W  patterns accepted in the current session

Behaviour:
- Reset is asynchronous: state=IDLE, signature=SEED, count=0, tpg_clear=0, busy=0, done=0, pass=0.
- All outputs are registered or decoded directly from state. There is no combinational path from inputs to outputs.
- MISR update on an accepted result r:
  - sig'[0] = sig[RES_W-1] ^ r[0]
  - for i ≥ 1: sig'[i] = sig[i-1] ^ r[i] ^ (MISR_POLY[i] & sig[RES_W-1])
- States: IDLE, RUN, CHECK, DONE.
- IDLE:
  - start=1 and abort=0: next RUN; signature <= SEED, count <= 0, pass <= 0, tpg_clear <= 1 for exactly the first RUN cycle.
  - res_valid is ignored.
- RUN:
  - Each cycle with res_valid=1 updates the MISR and increments count. This includes the first RUN cycle, coincident with tpg_clear.
  - res_valid=0: signature and count hold. There is no timeout.
  - When the accepted pattern makes count equal PATTERNS: next CHECK.
  - start is ignored.
- CHECK (one cycle): pass <= (signature == GOLDEN); next DONE.
- DONE:
  - done=1; pass, signature and count are held stable.
  - start=1: restarts exactly as from IDLE, with done dropping the next cycle.
  - res_valid is ignored.
- abort=1 in any state: next IDLE, pass <= 0, done drops next cycle; signature and count hold their last values.
  - abort has priority over start and over res_valid in the same cycle.
- Latency: last accepted pattern at cycle K gives CHECK at K+1, and done=1 with a valid pass at K+2.
- count never wraps: the transition to CHECK occurs exactly at PATTERNS.
- Reset asserted mid-session returns to the reset values immediately, with no done pulse.

Test Plan:
1. Reset held, then released with no start -> state IDLE, signature=0, count=0, busy=0, done=0, pass=0; tpg_clear never pulses.
2. PATTERNS=1, SEED=0, GOLDEN=5'h13; start, then result=5'h13 with res_valid=1 in the first RUN cycle:
   - tpg_clear=1 for one cycle.
   - signature=5'h13, count=1.
   - done=1 and pass=1 two cycles after acceptance.
3. SEED=5'h10, PATTERNS=1, result=0 -> signature=5'h05 (feedback into bits 0 and 2); with GOLDEN=0, pass=0 and done=1.
4. Default parameters, 15 patterns of result=0 with res_valid deasserted on 3 interleaved cycles:
   - count advances only on valid cycles and reaches 15.
   - signature=0, pass=1.
   - busy stays high for 15 valid + 3 idle + 1 CHECK cycles.
5. abort asserted together with res_valid at count=7 -> IDLE next cycle, count stays 7, pass=0, done=0; a subsequent start reloads SEED and count=0.
6. In DONE with pass=1, assert start -> done=0 next cycle, busy=1, tpg_clear pulses; a second session of identical data reproduces the same signature and pass=1. Asynchronous reset mid-RUN -> all outputs at reset values at once.
